bp_be_mem_pipe_tracker: RTL

BP_BE_MEM_PIPE_TRACKER -- requirements
Module: bp_be_mem_pipe_tracker

---
 rtl/bp_be_pkg.sv | 45 ++++
 rtl/bp_be_mem_stage_reg.sv | 35 +++
 rtl/bp_be_mem_pipe_tracker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared types and constants for the back-end memory pipe tracker.
package bp_be_pkg;

  // Miss-handling controller states
  typedef enum logic [1:0] {
    e_mem_ready     = 2'd0,
    e_mem_miss_wait = 2'd1,
    e_mem_replay    = 2'd2
  } bp_be_mem_state_e;

  // RISC-V exception cause codes used by the memory pipe
  localparam logic [3:0] ecode_load_misaligned_gp  = 4'd4;
  localparam logic [3:0] ecode_load_access_gp      = 4'd5;
  localparam logic [3:0] ecode_store_misaligned_gp = 4'd6;
  localparam logic [3:0] ecode_store_access_gp     = 4'd7;
  localparam logic [3:0] ecode_load_page_gp        = 4'd13;
  localparam logic [3:0] ecode_store_page_gp       = 4'd15;

  // Per-request status bits carried alongside the address through the pipe
  typedef struct packed {
    logic load;
    logic store;
    logic fencei;
    logic misaligned;
    logic tlb_miss;
    logic page_fault;
    logic access_fault;
    logic cache_hit;
  } bp_be_mem_flags_s;

  // Natural-alignment check; fence.i carries no data access and is never misaligned
  function automatic logic bp_be_misaligned(input logic       fencei,
                                            input logic [1:0] size,
                                            input logic [2:0] addr_lo);
    logic mis;
    case (size)
      2'd1:    mis = addr_lo[0];
      2'd2:    mis = |addr_lo[1:0];
      2'd3:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis & ~fencei;
  endfunction

endpackage

// File: rtl/bp_be_mem_stage_reg.sv
// One pipeline stage: a valid bit plus an opaque payload, cleared by reset or kill.
module bp_be_mem_stage_reg
  import bp_be_pkg::*;
#(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               kill_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               r_v;
  logic [width_p-1:0] r_data;

  // Capture the incoming request; kill overrides an arriving valid
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
    end else begin
      r_v <= v_i & ~kill_i;
      if (v_i & ~kill_i) begin
        r_data <= data_i;
      end
    end
  end

  assign v_o    = r_v;
  assign data_o = r_data;

endmodule

// File: rtl/bp_be_mem_pipe_tracker.sv
// Tracks load/store/fence.i requests through a stages_p-deep memory pipe,
// resolves exceptions, TLB misses and D$ misses at the final stage, and
// runs the miss-wait / replay handshake.
module bp_be_mem_pipe_tracker
  import bp_be_pkg::*;
#(
  parameter  int unsigned vaddr_width_p  = 39,
  parameter  int unsigned stages_p       = 3,
  localparam int unsigned eaddr_width_lp = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      req_v_i,
  input  logic                      req_load_i,
  input  logic                      req_store_i,
  input  logic                      req_fencei_i,
  input  logic [1:0]                req_size_i,
  input  logic [eaddr_width_lp-1:0] req_eaddr_i,
  output logic                      ready_o,
  input  logic                      tlb_miss_i,
  input  logic                      page_fault_i,
  input  logic                      access_fault_i,
  input  logic                      cache_hit_i,
  input  logic                      miss_complete_i,
  output logic                      final_v_o,
  output logic [vaddr_width_p-1:0]  final_vaddr_o,
  output logic                      exc_v_o,
  output logic [3:0]                exc_code_o,
  output logic                      tlb_miss_o,
  output logic                      cache_miss_o,
  output logic                      fencei_v_o,
  output logic                      replay_o,
  output logic [vaddr_width_p-1:0]  replay_vaddr_o
);

  localparam int unsigned flags_width_lp = $bits(bp_be_mem_flags_s);
  localparam int unsigned stage_width_lp = flags_width_lp + vaddr_width_p;

  bp_be_mem_state_e r_state, w_state_nxt;
  logic             r_kill, w_kill_nxt;
  logic [vaddr_width_p-1:0] r_replay_vaddr;

  logic                                   w_accept;
  logic                                   w_stage_kill;
  logic [stages_p-1:0]                    w_v_q;
  bp_be_mem_flags_s [stages_p-1:0]        w_flags_q;
  logic [stages_p-1:0][vaddr_width_p-1:0] w_addr_q;

  bp_be_mem_flags_s         w_fin;
  logic [vaddr_width_p-1:0] w_fin_addr;
  logic                     w_fin_v;
  logic                     w_fin_mem;

  assign w_accept     = req_v_i & ready_o & ~flush_i;
  assign w_stage_kill = flush_i | cache_miss_o;

  for (genvar i = 0; i < stages_p; i++) begin : g_stage
    logic                      w_v_d;
    bp_be_mem_flags_s          w_flags_d;
    logic [vaddr_width_p-1:0]  w_addr_d;
    logic [stage_width_lp-1:0] w_data_q;

    if (i == 0) begin : g_head
      // Stage 1 is loaded from the accepted request; alignment is resolved here
      always_comb begin
        w_flags_d            = '0;
        w_flags_d.load       = req_load_i;
        w_flags_d.store      = req_store_i;
        w_flags_d.fencei     = req_fencei_i;
        w_flags_d.misaligned = bp_be_misaligned(req_fencei_i, req_size_i, req_eaddr_i[2:0]);
      end
      assign w_v_d    = w_accept;
      assign w_addr_d = req_eaddr_i[vaddr_width_p-1:0];
    end else begin : g_body
      // Forward the older stage, folding in the lookups that belong to it
      always_comb begin
        w_flags_d = w_flags_q[i-1];
        if (w_v_q[i-1]) begin
          if (i == 1) begin
            w_flags_d.tlb_miss     = tlb_miss_i;
            w_flags_d.page_fault   = page_fault_i;
            w_flags_d.access_fault = access_fault_i;
          end
          if (i == int'(stages_p) - 1) begin
            w_flags_d.cache_hit = cache_hit_i;
          end
        end
      end
      assign w_v_d    = w_v_q[i-1];
      assign w_addr_d = w_addr_q[i-1];
    end

    bp_be_mem_stage_reg #(
      .width_p(stage_width_lp)
    ) u_stage_reg (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .kill_i (w_stage_kill),
      .v_i    (w_v_d),
      .data_i ({w_flags_d, w_addr_d}),
      .v_o    (w_v_q[i]),
      .data_o (w_data_q)
    );

    assign w_flags_q[i] = w_data_q[stage_width_lp-1 -: flags_width_lp];
    assign w_addr_q[i]  = w_data_q[vaddr_width_p-1:0];
  end

  if (vaddr_width_p < eaddr_width_lp) begin : g_unused
    logic w_unused_eaddr;
    assign w_unused_eaddr = ^req_eaddr_i[eaddr_width_lp-1:vaddr_width_p];
  end

  assign w_fin      = w_flags_q[stages_p-1];
  assign w_fin_addr = w_addr_q[stages_p-1];
  // A flush kills the final-stage request before it can report anything
  assign w_fin_v    = w_v_q[stages_p-1] & ~flush_i;
  assign w_fin_mem  = w_fin.load | w_fin.store;

  // Final-stage resolution: exactly one event, highest priority first
  always_comb begin
    exc_v_o       = 1'b0;
    exc_code_o    = '0;
    tlb_miss_o    = 1'b0;
    fencei_v_o    = 1'b0;
    final_v_o     = 1'b0;
    final_vaddr_o = '0;
    cache_miss_o  = 1'b0;
    if (w_fin_v) begin
      if (w_fin_mem & (w_fin.misaligned | w_fin.page_fault | w_fin.access_fault)) begin
        exc_v_o = 1'b1;
        if (w_fin.store) begin
          exc_code_o = w_fin.misaligned ? ecode_store_misaligned_gp
                     : w_fin.page_fault ? ecode_store_page_gp
                     :                    ecode_store_access_gp;
        end else begin
          exc_code_o = w_fin.misaligned ? ecode_load_misaligned_gp
                     : w_fin.page_fault ? ecode_load_page_gp
                     :                    ecode_load_access_gp;
        end
      end else if (w_fin.tlb_miss) begin
        tlb_miss_o = 1'b1;
      end else if (w_fin.fencei & w_fin.cache_hit) begin
        fencei_v_o = 1'b1;
      end else if (w_fin_mem & w_fin.cache_hit) begin
        final_v_o     = 1'b1;
        final_vaddr_o = w_fin_addr;
      end else begin
        cache_miss_o = 1'b1;
      end
    end
  end

  // Miss controller next state; a flush while waiting cancels the replay
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    case (r_state)
      e_mem_ready: begin
        if (cache_miss_o) begin
          w_state_nxt = e_mem_miss_wait;
          w_kill_nxt  = 1'b0;
        end
      end
      e_mem_miss_wait: begin
        if (flush_i) begin
          w_kill_nxt = 1'b1;
        end
        if (miss_complete_i) begin
          w_state_nxt = (r_kill | flush_i) ? e_mem_ready : e_mem_replay;
          w_kill_nxt  = 1'b0;
        end
      end
      e_mem_replay: begin
        w_state_nxt = e_mem_ready;
      end
      default: begin
        w_state_nxt = e_mem_ready;
        w_kill_nxt  = 1'b0;
      end
    endcase
  end

  // Miss controller state, kill flag and replay address registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= e_mem_ready;
      r_kill         <= 1'b0;
      r_replay_vaddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
      if (cache_miss_o) begin
        r_replay_vaddr <= w_fin_addr;
      end
    end
  end

  assign ready_o        = (r_state == e_mem_ready) & ~cache_miss_o;
  assign replay_o       = (r_state == e_mem_replay) & ~flush_i;
  assign replay_vaddr_o = replay_o ? r_replay_vaddr : '0;

endmodule
